// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: ping-pong pixel buffer between the filter pipeline and an
// Avalon-MM write master. One bank fills while the other drains as single-word
// writes with a running word address.
// Optional feature macro: PIXEL_WRITE_BUFFER_FLUSH_EN adds a 'flush' input that
// closes a partially filled bank so it drains with its actual length.
module pixel_write_buffer #(
    parameter int PIXEL_W  = 24,
    parameter int DEPTH    = 6,
    parameter int ADDR_W   = 32,
    parameter int ADDR_INC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_address,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_valid,
    output logic               pixel_ready,
`ifdef PIXEL_WRITE_BUFFER_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               master_waitrequest,
    output logic               master_write,
    output logic [ADDR_W-1:0]  master_address,
    output logic [PIXEL_W-1:0] master_writedata,
    output logic               done_write,
    output logic               busy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] INC_C   = ADDR_W'(ADDR_INC);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    logic [PIXEL_W-1:0] r_mem [2][DEPTH];
    logic               r_full [2];
    logic [CNT_W-1:0]   r_len [2];
    logic               r_fill_sel;
    logic               r_drain_sel;
    logic [CNT_W-1:0]   r_fill_cnt;
    logic [CNT_W-1:0]   r_drn_cnt;
    logic [ADDR_W-1:0]  r_cur_addr;
    state_t             r_state;
    logic               r_master_write;
    logic [PIXEL_W-1:0] r_writedata;
    logic               r_done;

    logic               w_pix_acc;
    logic [CNT_W-1:0]   w_fill_cnt_inc;
    logic               w_flush_req;
    logic               w_close;
    logic               w_word_acc;
    logic               w_drain_last;
    logic               w_idle;
    logic               w_start_acc;
    logic [CNT_W-1:0]   w_drn_next;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [IDX_W-1:0]   w_drn_idx;

`ifdef PIXEL_WRITE_BUFFER_FLUSH_EN
    assign w_flush_req = flush;
`else
    assign w_flush_req = 1'b0;
`endif

    // The fill bank only accepts pixels while it is EMPTY.
    assign pixel_ready    = !r_full[r_fill_sel];
    assign w_pix_acc      = pixel_valid && pixel_ready;
    // A pixel accepted together with flush is counted before the bank closes.
    assign w_fill_cnt_inc = r_fill_cnt + CNT_W'(w_pix_acc);
    assign w_close        = (w_fill_cnt_inc == DEPTH_C) ||
                            (w_flush_req && (w_fill_cnt_inc != '0));
    assign w_fill_idx     = r_fill_cnt[IDX_W-1:0];

    assign w_word_acc     = r_master_write && !master_waitrequest;
    assign w_drain_last   = w_word_acc && (r_drn_cnt == (r_len[r_drain_sel] - CNT_W'(1)));
    assign w_drn_next     = r_drn_cnt + CNT_W'(1);
    assign w_drn_idx      = w_drn_next[IDX_W-1:0];

    assign w_idle         = !r_full[0] && !r_full[1] && !r_master_write;
    assign w_start_acc    = start && w_idle;

    assign master_write     = r_master_write;
    assign master_address   = r_cur_addr;
    assign master_writedata = r_writedata;
    assign done_write       = r_done;
    assign busy             = r_full[0] || r_full[1] || r_master_write;

    // Fill pointer: count pixels into the fill bank and hop banks when it closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt <= '0;
            r_fill_sel <= 1'b0;
        end else if (w_close) begin
            r_fill_cnt <= '0;
            r_fill_sel <= ~r_fill_sel;
        end else begin
            r_fill_cnt <= w_fill_cnt_inc;
        end
    end

    // Per-bank storage and FULL/EMPTY status. Fill and drain never target the
    // same bank in one cycle, so set and clear cannot collide.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        // Bank storage write, length capture and status transitions.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_full[gi] <= 1'b0;
                r_len[gi]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[gi][i] <= '0;
                end
            end else begin
                if (w_pix_acc && (r_fill_sel == 1'(gi))) begin
                    r_mem[gi][w_fill_idx] <= pixel_data;
                end
                if (w_close && (r_fill_sel == 1'(gi))) begin
                    r_full[gi] <= 1'b1;
                    r_len[gi]  <= w_fill_cnt_inc;
                end else if (w_drain_last && (r_drain_sel == 1'(gi))) begin
                    r_full[gi] <= 1'b0;
                end
            end
        end
    end

    // Drain FSM: registered Avalon outputs, held while waitrequest is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_master_write <= 1'b0;
            r_writedata    <= '0;
            r_done         <= 1'b0;
            r_drn_cnt      <= '0;
            r_drain_sel    <= 1'b0;
            r_cur_addr     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                r_cur_addr <= base_address;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_drain_sel]) begin
                        r_state        <= S_WRITE;
                        r_master_write <= 1'b1;
                        r_drn_cnt      <= '0;
                        r_writedata    <= r_mem[r_drain_sel][0];
                    end
                end
                S_WRITE: begin
                    if (w_word_acc) begin
                        r_cur_addr <= r_cur_addr + INC_C;
                        if (w_drain_last) begin
                            r_drain_sel <= ~r_drain_sel;
                            r_drn_cnt   <= '0;
                            r_done      <= 1'b1;
                            // Chain straight into the other bank when it is already waiting.
                            if (r_full[~r_drain_sel]) begin
                                r_writedata <= r_mem[~r_drain_sel][0];
                            end else begin
                                r_state        <= S_IDLE;
                                r_master_write <= 1'b0;
                            end
                        end else begin
                            r_drn_cnt   <= w_drn_next;
                            r_writedata <= r_mem[r_drain_sel][w_drn_idx];
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_master_write <= 1'b0;
                end
            endcase
        end
    end
endmodule
